// File: rtl/draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : draw_scheduler
// Brief   : Queues drawing commands and sequences the fill, circle and
//           Reuleaux engines onto one shared VGA plot port.
// Rev     : 1.0  initial release
// ============================================================================
module draw_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [2:0]                cmd_colour,
    input  logic [7:0]                cmd_x,
    input  logic [6:0]                cmd_y,
    input  logic [7:0]                cmd_size,
    input  logic                      flush,
    output logic [2:0]                eng_colour,
    output logic [7:0]                eng_x,
    output logic [6:0]                eng_y,
    output logic [7:0]                eng_size,
    output logic                      fill_start,
    output logic                      circ_start,
    output logic                      reul_start,
    input  logic                      fill_done,
    input  logic                      circ_done,
    input  logic                      reul_done,
    input  logic [7:0]                fill_vga_x,
    input  logic [6:0]                fill_vga_y,
    input  logic [2:0]                fill_vga_colour,
    input  logic                      fill_vga_plot,
    input  logic [7:0]                circ_vga_x,
    input  logic [6:0]                circ_vga_y,
    input  logic [2:0]                circ_vga_colour,
    input  logic                      circ_vga_plot,
    input  logic [7:0]                reul_vga_x,
    input  logic [6:0]                reul_vga_y,
    input  logic [2:0]                reul_vga_colour,
    input  logic                      reul_vga_plot,
    output logic [7:0]                vga_x,
    output logic [6:0]                vga_y,
    output logic [2:0]                vga_colour,
    output logic                      vga_plot,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    level,
    output logic [7:0]                done_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0]  c_OP_CLEAR  = 2'd0;
    localparam logic [1:0]  c_OP_CIRCLE = 2'd1;
    localparam logic [1:0]  c_OP_REUL   = 2'd2;
    localparam logic [1:0]  c_OP_NOP    = 2'd3;
    localparam logic [AW:0] c_FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [1:0]   r_mem_op     [DEPTH];
    logic [2:0]   r_mem_colour [DEPTH];
    logic [7:0]   r_mem_x      [DEPTH];
    logic [6:0]   r_mem_y      [DEPTH];
    logic [7:0]   r_mem_size   [DEPTH];

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [AW:0]  w_level;
    logic         w_empty;
    logic         w_full;
    logic         w_push;
    logic         w_pop;

    logic [1:0]   r_cur_op;
    logic [2:0]   r_eng_colour;
    logic [7:0]   r_eng_x;
    logic [6:0]   r_eng_y;
    logic [7:0]   r_eng_size;
    logic         r_fill_start;
    logic         r_circ_start;
    logic         r_reul_start;
    logic [7:0]   r_done_count;
    logic         w_sel_done;
    logic         w_count_done;

    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == c_FULL_LEVEL);
    // Flush wins over both ends of the queue so nothing queued this cycle survives.
    assign w_push  = cmd_valid & ~w_full & ~flush;
    assign w_pop   = (r_state == S_IDLE) & ~w_empty & ~flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr[AW-1:0]]     <= cmd_op;
            r_mem_colour[r_wr_ptr[AW-1:0]] <= cmd_colour;
            r_mem_x[r_wr_ptr[AW-1:0]]      <= cmd_x;
            r_mem_y[r_wr_ptr[AW-1:0]]      <= cmd_y;
            r_mem_size[r_wr_ptr[AW-1:0]]   <= cmd_size;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_comb begin
        w_sel_done = 1'b0;
        case (r_cur_op)
            c_OP_CLEAR:  w_sel_done = fill_done;
            c_OP_CIRCLE: w_sel_done = circ_done;
            c_OP_REUL:   w_sel_done = reul_done;
            default:     w_sel_done = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pop) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (r_cur_op == c_OP_NOP) begin
                    w_state_nxt  = S_IDLE;
                    w_count_done = 1'b1;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_sel_done) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!w_sel_done) begin
                    w_state_nxt  = S_IDLE;
                    w_count_done = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cur_op     <= c_OP_CLEAR;
            r_eng_colour <= '0;
            r_eng_x      <= '0;
            r_eng_y      <= '0;
            r_eng_size   <= '0;
            r_fill_start <= 1'b0;
            r_circ_start <= 1'b0;
            r_reul_start <= 1'b0;
            r_done_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_cur_op     <= r_mem_op[r_rd_ptr[AW-1:0]];
                r_eng_colour <= r_mem_colour[r_rd_ptr[AW-1:0]];
                r_eng_x      <= r_mem_x[r_rd_ptr[AW-1:0]];
                r_eng_y      <= r_mem_y[r_rd_ptr[AW-1:0]];
                r_eng_size   <= r_mem_size[r_rd_ptr[AW-1:0]];
            end
            // Decoding from the next state keeps each start high for exactly the RUN cycles.
            r_fill_start <= (w_state_nxt == S_RUN) && (r_cur_op == c_OP_CLEAR);
            r_circ_start <= (w_state_nxt == S_RUN) && (r_cur_op == c_OP_CIRCLE);
            r_reul_start <= (w_state_nxt == S_RUN) && (r_cur_op == c_OP_REUL);
            if (w_count_done) r_done_count <= r_done_count + 8'd1;
        end
    end

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        if (r_state == S_RUN) begin
            case (r_cur_op)
                c_OP_CLEAR: begin
                    vga_x = fill_vga_x; vga_y = fill_vga_y;
                    vga_colour = fill_vga_colour; vga_plot = fill_vga_plot;
                end
                c_OP_CIRCLE: begin
                    vga_x = circ_vga_x; vga_y = circ_vga_y;
                    vga_colour = circ_vga_colour; vga_plot = circ_vga_plot;
                end
                c_OP_REUL: begin
                    vga_x = reul_vga_x; vga_y = reul_vga_y;
                    vga_colour = reul_vga_colour; vga_plot = reul_vga_plot;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready  = ~w_full;
    assign level      = w_level;
    assign busy       = (r_state != S_IDLE) | ~w_empty;
    assign done_count = r_done_count;
    assign eng_colour = r_eng_colour;
    assign eng_x      = r_eng_x;
    assign eng_y      = r_eng_y;
    assign eng_size   = r_eng_size;
    assign fill_start = r_fill_start;
    assign circ_start = r_circ_start;
    assign reul_start = r_reul_start;

endmodule
`default_nettype wire

// File: tb/tb_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_draw_scheduler
// Brief   : Self-checking bench for draw_scheduler with behavioural engine
//           models and a command-queue reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_draw_scheduler;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [1:0] OP_CLEAR = 2'd0, OP_CIRCLE = 2'd1, OP_REUL = 2'd2, OP_NOP = 2'd3;
    localparam int M_NORMAL = 0, M_STALL = 1, M_HIGH = 2, M_RANDOM = 3;

    typedef struct {
        logic [1:0] op;
        logic [2:0] col;
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] sz;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = '0;
    logic [2:0]    cmd_colour = '0;
    logic [7:0]    cmd_x = '0;
    logic [6:0]    cmd_y = '0;
    logic [7:0]    cmd_size = '0;
    logic          flush = 1'b0;
    logic          cmd_ready;
    logic [2:0]    eng_colour;
    logic [7:0]    eng_x;
    logic [6:0]    eng_y;
    logic [7:0]    eng_size;
    logic          fill_start, circ_start, reul_start;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [2:0]    vga_colour;
    logic          vga_plot;
    logic          busy;
    logic [LW-1:0] level;
    logic [7:0]    done_count;

    // Engine models: index 0 = fill, 1 = circle, 2 = Reuleaux
    logic [2:0] e_done = '0;
    logic [7:0] e_x   [3] = '{8'd0, 8'd0, 8'd0};
    logic [6:0] e_y   [3] = '{7'd0, 7'd0, 7'd0};
    logic [2:0] e_col [3] = '{3'd0, 3'd0, 3'd0};
    logic       e_plot[3] = '{1'b0, 1'b0, 1'b0};
    int e_mode [3] = '{0, 0, 0};
    int e_delay[3] = '{20, 20, 20};
    int e_cnt  [3] = '{0, 0, 0};

    logic [2:0] w_starts;
    assign w_starts = {reul_start, circ_start, fill_start};

    int errors = 0;
    int checks = 0;
    int mon_viol = 0;

    draw_scheduler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_colour(cmd_colour), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_size(cmd_size),
        .flush(flush),
        .eng_colour(eng_colour), .eng_x(eng_x), .eng_y(eng_y), .eng_size(eng_size),
        .fill_start(fill_start), .circ_start(circ_start), .reul_start(reul_start),
        .fill_done(e_done[0]), .circ_done(e_done[1]), .reul_done(e_done[2]),
        .fill_vga_x(e_x[0]), .fill_vga_y(e_y[0]), .fill_vga_colour(e_col[0]), .fill_vga_plot(e_plot[0]),
        .circ_vga_x(e_x[1]), .circ_vga_y(e_y[1]), .circ_vga_colour(e_col[1]), .circ_vga_plot(e_plot[1]),
        .reul_vga_x(e_x[2]), .reul_vga_y(e_y[2]), .reul_vga_colour(e_col[2]), .reul_vga_plot(e_plot[2]),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .level(level), .done_count(done_count)
    );

    // Engines react on the falling edge; pixel outputs are random noise every cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            e_x[k]    = 8'($urandom);
            e_y[k]    = 7'($urandom);
            e_col[k]  = 3'($urandom);
            e_plot[k] = 1'($urandom);
            if (w_starts[k]) e_cnt[k] = e_cnt[k] + 1;
            else             e_cnt[k] = 0;
            case (e_mode[k])
                M_NORMAL: e_done[k] = w_starts[k] && (e_cnt[k] >= e_delay[k]);
                M_STALL:  e_done[k] = 1'b0;
                M_HIGH:   e_done[k] = 1'b1;
                default:  e_done[k] = 1'($urandom);
            endcase
        end
    end

    // Pixel port must follow the single active engine, and be silent when none runs.
    always @(posedge clk) begin
        #1;
        if ($countones(w_starts) > 1) mon_viol++;
        else if (w_starts == 3'b000) begin
            if ({vga_plot, vga_x, vga_y, vga_colour} !== 19'd0) mon_viol++;
        end else begin
            for (int k = 0; k < 3; k++)
                if (w_starts[k] && {vga_plot, vga_x, vga_y, vga_colour} !== {e_plot[k], e_x[k], e_y[k], e_col[k]})
                    mon_viol++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_modes(input int mode, input int delay);
        foreach (e_mode[k]) begin
            e_mode[k]  = mode;
            e_delay[k] = delay;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; flush = 1'b0;
        set_modes(M_NORMAL, 20);
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [1:0] op, input logic [2:0] col, input logic [7:0] x,
                        input logic [6:0] y, input logic [7:0] sz);
        cmd_op = op; cmd_colour = col; cmd_x = x; cmd_y = y; cmd_size = sz;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (level !== 0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_fifo: level=%0d cmd_ready=%0b, expected 0 and 1", level, cmd_ready);
        end
        checks++;
        if (busy !== 1'b0 || done_count !== 8'd0) begin
            errors++; $display("FAIL reset_status: busy=%0b done_count=%0d, expected 0 and 0", busy, done_count);
        end
        checks++;
        if (w_starts !== 3'b000 || vga_plot !== 1'b0) begin
            errors++; $display("FAIL reset_starts: starts=%b vga_plot=%0b, expected 000 and 0", w_starts, vga_plot);
        end
        checks++;
        if ({eng_colour, eng_x, eng_y, eng_size} !== 26'd0) begin
            errors++; $display("FAIL reset_eng: eng=%h, expected 0", {eng_colour, eng_x, eng_y, eng_size});
        end
        rst = 1'b0;
    endtask

    task automatic test_single_circle();
        int hi = 0;
        bit eng_ok = 1'b1;
        do_reset();
        e_delay[1] = 100;
        push(OP_CIRCLE, 3'b010, 8'd80, 7'd60, 8'd40);
        checks++;
        if (circ_start !== 1'b0 || level !== 1) begin
            errors++; $display("FAIL circle_accept: circ_start=%0b level=%0d, expected 0 and 1", circ_start, level);
        end
        tick();
        checks++;
        if (circ_start !== 1'b0 || level !== 0 || busy !== 1'b1) begin
            errors++; $display("FAIL circle_pop: circ_start=%0b level=%0d busy=%0b, expected 0 0 1", circ_start, level, busy);
        end
        tick();
        checks++;
        if (circ_start !== 1'b1) begin
            errors++; $display("FAIL circle_start_rise: circ_start=%0b two cycles after accept, expected 1", circ_start);
        end
        while (circ_start === 1'b1 && hi < 400) begin
            hi++;
            if ({eng_colour, eng_x, eng_y, eng_size} !== {3'b010, 8'd80, 7'd60, 8'd40}) eng_ok = 1'b0;
            tick();
        end
        checks++;
        if (hi != 100) begin
            errors++; $display("FAIL circle_start_len: start high %0d cycles, expected 100", hi);
        end
        checks++;
        if (!eng_ok || eng_x !== 8'd80 || eng_y !== 7'd60 || eng_size !== 8'd40) begin
            errors++; $display("FAIL circle_eng: eng_x=%0d eng_y=%0d eng_size=%0d not stable, expected 80 60 40", eng_x, eng_y, eng_size);
        end
        checks++;
        if (done_count !== 8'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL circle_release: done_count=%0d busy=%0b, expected 0 and 1", done_count, busy);
        end
        tick();
        checks++;
        if (done_count !== 8'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL circle_done: done_count=%0d busy=%0b, expected 1 and 0", done_count, busy);
        end
    endtask

    task automatic test_back_to_back();
        int order[$];
        logic [2:0] prev = 3'b000, rise;
        int low = 0, min_gap = 1000, cyc = 0, viol0;
        bit seen_high = 1'b0;
        logic [1:0] ops[4] = '{OP_CLEAR, OP_CIRCLE, OP_REUL, OP_NOP};
        do_reset();
        viol0 = mon_viol;
        while (cyc < 400 && (cyc < 4 || busy === 1'b1)) begin
            if (cyc < 4) begin
                cmd_valid = 1'b1; cmd_op = ops[cyc]; cmd_x = 8'(cyc);
            end else cmd_valid = 1'b0;
            tick(); cyc++;
            rise = w_starts & ~prev;
            prev = w_starts;
            if (w_starts == 3'b000) low++;
            else begin
                if (rise != 3'b000 && seen_high && low < min_gap) min_gap = low;
                if (rise != 3'b000) for (int k = 0; k < 3; k++) if (rise[k]) order.push_back(k);
                seen_high = 1'b1; low = 0;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
            errors++; $display("FAIL b2b_order: %0d starts seen, order %p, expected fill circ reul", order.size(), order);
        end
        checks++;
        if (min_gap < 3) begin
            errors++; $display("FAIL b2b_gap: min low gap %0d cycles, expected >= 3", min_gap);
        end
        checks++;
        if (done_count !== 8'd4 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_done: done_count=%0d busy=%0b, expected 4 and 0", done_count, busy);
        end
        checks++;
        if (mon_viol != viol0) begin
            errors++; $display("FAIL b2b_pixel_mux: %0d mux violations, expected 0", mon_viol - viol0);
        end
    endtask

    task automatic test_full();
        int t = 0;
        do_reset();
        set_modes(M_STALL, 3);
        for (int i = 0; i < 5; i++) push(OP_CIRCLE, 3'd1, 8'(i), 7'd5, 8'd9);
        checks++;
        if (level !== 4 || cmd_ready !== 1'b0 || circ_start !== 1'b1) begin
            errors++; $display("FAIL full_level: level=%0d cmd_ready=%0b circ_start=%0b, expected 4 0 1", level, cmd_ready, circ_start);
        end
        cmd_valid = 1'b1; cmd_x = 8'd5;
        repeat (3) tick();
        cmd_valid = 1'b0;
        checks++;
        if (level !== 4 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL full_extra_push: level=%0d cmd_ready=%0b, expected 4 and 0", level, cmd_ready);
        end
        e_mode[1] = M_NORMAL;
        while (level !== 3 && t < 20) begin tick(); t++; end
        checks++;
        if (level !== 3 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL full_after_pop: level=%0d cmd_ready=%0b, expected 3 and 1", level, cmd_ready);
        end
        set_modes(M_NORMAL, 3);
        t = 0;
        while (busy === 1'b1 && t < 500) begin tick(); t++; end
        checks++;
        if (busy !== 1'b0 || done_count !== 8'd5 || eng_x !== 8'd4) begin
            errors++; $display("FAIL full_drain: busy=%0b done_count=%0d last eng_x=%0d, expected 0 5 4", busy, done_count, eng_x);
        end
    endtask

    task automatic test_flush();
        int t = 0, other = 0;
        do_reset();
        e_mode[1] = M_STALL;
        push(OP_CIRCLE, 3'd3, 8'd11, 7'd12, 8'd13);
        while (circ_start !== 1'b1 && t < 10) begin tick(); t++; end
        for (int i = 0; i < 3; i++) push(OP_CLEAR, 3'd0, 8'(21 + i), 7'd0, 8'd0);
        checks++;
        if (level !== 3 || circ_start !== 1'b1) begin
            errors++; $display("FAIL flush_setup: level=%0d circ_start=%0b, expected 3 and 1", level, circ_start);
        end
        flush = 1'b1;
        push(OP_REUL, 3'd7, 8'd99, 7'd9, 8'd9);
        flush = 1'b0;
        checks++;
        if (level !== 0 || circ_start !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL flush_level: level=%0d circ_start=%0b busy=%0b, expected 0 1 1", level, circ_start, busy);
        end
        e_mode[1] = M_NORMAL; e_delay[1] = 5;
        t = 0;
        while (busy === 1'b1 && t < 200) begin
            tick(); t++;
            if (fill_start === 1'b1 || reul_start === 1'b1) other++;
        end
        checks++;
        if (busy !== 1'b0 || done_count !== 8'd1 || other != 0 || eng_x !== 8'd11) begin
            errors++; $display("FAIL flush_complete: busy=%0b done_count=%0d other_starts=%0d eng_x=%0d, expected 0 1 0 11",
                               busy, done_count, other, eng_x);
        end
    endtask

    task automatic test_reset_mid_run();
        int t = 0, spurious = 0;
        do_reset();
        e_mode[1] = M_STALL;
        push(OP_NOP, 3'd0, 8'd0, 7'd0, 8'd0);
        push(OP_CIRCLE, 3'd2, 8'd40, 7'd30, 8'd20);
        push(OP_CLEAR, 3'd1, 8'd1, 7'd1, 8'd1);
        push(OP_CLEAR, 3'd1, 8'd2, 7'd2, 8'd2);
        while (circ_start !== 1'b1 && t < 10) begin tick(); t++; end
        checks++;
        if (circ_start !== 1'b1 || done_count !== 8'd1 || level === 0) begin
            errors++; $display("FAIL rstrun_setup: circ_start=%0b done_count=%0d level=%0d, expected 1 1 nonzero", circ_start, done_count, level);
        end
        rst = 1'b1;
        e_mode[1] = M_HIGH;
        tick();
        checks++;
        if (w_starts !== 3'b000 || level !== 0 || done_count !== 8'd0 || vga_plot !== 1'b0) begin
            errors++; $display("FAIL rstrun_clear: starts=%b level=%0d done_count=%0d vga_plot=%0b, expected 000 0 0 0",
                               w_starts, level, done_count, vga_plot);
        end
        rst = 1'b0;
        repeat (10) begin
            tick();
            if (w_starts !== 3'b000) spurious++;
        end
        checks++;
        if (spurious != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstrun_no_start: %0d start cycles, busy=%0b, expected 0 and 0", spurious, busy);
        end
        e_mode[1] = M_NORMAL;
        repeat (2) tick();
    endtask

    task automatic test_stray_done();
        int t = 0, hi = 0, reul_hi = 0;
        do_reset();
        e_delay[1] = 30;
        e_mode[2]  = M_RANDOM;
        push(OP_CIRCLE, 3'd4, 8'd50, 7'd50, 8'd10);
        while (circ_start !== 1'b1 && t < 10) begin tick(); t++; end
        while (circ_start === 1'b1 && hi < 200) begin
            hi++;
            if (reul_start === 1'b1) reul_hi++;
            tick();
        end
        t = 0;
        while (busy === 1'b1 && t < 20) begin tick(); t++; end
        checks++;
        if (hi != 30 || reul_hi != 0) begin
            errors++; $display("FAIL stray_done_len: circ_start high %0d cycles reul_start %0d, expected 30 and 0", hi, reul_hi);
        end
        checks++;
        if (done_count !== 8'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL stray_done_count: done_count=%0d busy=%0b, expected 1 and 0", done_count, busy);
        end
        e_mode[2] = M_NORMAL;
        repeat (2) tick();
    endtask

    task automatic test_nop_wrap();
        int n = 0, cyc = 0;
        bit seen255 = 1'b0;
        logic rdy;
        do_reset();
        cmd_op = OP_NOP;
        while (n < 256 && cyc < 5000) begin
            cmd_valid = 1'b1;
            rdy = cmd_ready;
            tick(); cyc++;
            if (rdy) n++;
            if (done_count === 8'd255) seen255 = 1'b1;
        end
        cmd_valid = 1'b0;
        while (busy === 1'b1 && cyc < 6000) begin
            tick(); cyc++;
            if (done_count === 8'd255) seen255 = 1'b1;
        end
        checks++;
        if (n != 256 || busy !== 1'b0) begin
            errors++; $display("FAIL nop_accept: %0d NOPs accepted busy=%0b, expected 256 and 0", n, busy);
        end
        checks++;
        if (!seen255 || done_count !== 8'd0) begin
            errors++; $display("FAIL nop_wrap: saw255=%0b done_count=%0d, expected 1 and 0", seen255, done_count);
        end
    endtask

    task automatic test_random_stream();
        cmd_t q[$];
        cmd_t c, e;
        logic [2:0] prev = 3'b000, rise;
        logic rdy, drv;
        int acc = 0, cyc = 0, leftover = 0;
        do_reset();
        foreach (e_mode[k]) begin
            e_mode[k]  = M_NORMAL;
            e_delay[k] = $urandom_range(1, 12);
        end
        while ((acc < 40 || busy === 1'b1) && cyc < 20000) begin
            drv   = (acc < 40) && ($urandom_range(0, 2) != 0);
            c.op  = 2'($urandom); c.col = 3'($urandom); c.x = 8'($urandom);
            c.y   = 7'($urandom); c.sz  = 8'($urandom);
            cmd_valid = drv; cmd_op = c.op; cmd_colour = c.col;
            cmd_x = c.x; cmd_y = c.y; cmd_size = c.sz;
            rdy = cmd_ready;
            tick(); cyc++;
            if (drv && rdy) begin q.push_back(c); acc++; end
            rise = w_starts & ~prev;
            prev = w_starts;
            if (rise != 3'b000) begin
                while (q.size() > 0 && q[0].op == OP_NOP) void'(q.pop_front());
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_start: starts rose %b with no pending command in model", rise);
                end else begin
                    e = q.pop_front();
                    if (rise !== (3'b001 << e.op) || {eng_colour, eng_x, eng_y, eng_size} !== {e.col, e.x, e.y, e.sz}) begin
                        errors++;
                        $display("FAIL rand_start: rise=%b eng=%h, expected rise=%b eng=%h", rise,
                                 {eng_colour, eng_x, eng_y, eng_size}, 3'b001 << e.op, {e.col, e.x, e.y, e.sz});
                    end
                end
            end
        end
        cmd_valid = 1'b0;
        foreach (q[i]) if (q[i].op != OP_NOP) leftover++;
        checks++;
        if (cyc >= 20000 || leftover != 0 || level !== 0) begin
            errors++; $display("FAIL rand_drain: cycles=%0d unstarted=%0d level=%0d, expected <20000 0 0", cyc, leftover, level);
        end
        checks++;
        if (done_count !== 8'(acc)) begin
            errors++; $display("FAIL rand_done_count: done_count=%0d, expected %0d", done_count, acc);
        end
    endtask

    task automatic test_pixel_mux();
        checks++;
        if (mon_viol != 0) begin
            errors++; $display("FAIL pixel_mux: %0d cycles with wrong pixel source or overlapping starts, expected 0", mon_viol);
        end
    endtask

    initial begin
        test_reset();
        test_single_circle();
        test_back_to_back();
        test_full();
        test_flush();
        test_reset_mid_run();
        test_stray_done();
        test_nop_wrap();
        test_random_stream();
        test_pixel_mux();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
